// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory read handshake plus IR load/flush bundle.
// master is the fetch controller; slave is the memory/decode side.
interface fetch_ctrl_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ir_load;
    logic        ir_flush;
    logic [31:0] ir_in;
    logic [31:0] ir_pc;
    modport master (
        output imem_read, imem_address, ir_load, ir_flush, ir_in, ir_pc,
        input  imem_resp, imem_rdata, stall, redirect, redirect_pc
    );
    modport slave (
        input  imem_read, imem_address, ir_load, ir_flush, ir_in, ir_pc,
        output imem_resp, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC, drives the imem read handshake and IR strobes,
// absorbs decode stalls in a one-entry hold buffer and squashes redirected fetches.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input logic          clk,
    input logic          rst_n,
    fetch_ctrl_if.master io_f
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, SQUASH} state_t;
    state_t      r_state;
    logic        r_read;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_hold_buf;
    logic [31:0] r_hold_pc;
    logic [31:0] w_next_addr;
    logic        w_in_hold;
    assign w_next_addr       = r_req_addr + 32'd4;
    assign w_in_hold         = r_state == HOLD;
    assign io_f.imem_read    = r_read;
    assign io_f.imem_address = r_req_addr;
    // Strobes are combinational so the IR captures in the same cycle as imem_resp.
    assign io_f.ir_flush = io_f.redirect && r_state != IDLE;
    assign io_f.ir_load  = !io_f.redirect && !io_f.stall &&
                           (w_in_hold || (r_state == REQ && io_f.imem_resp));
    assign io_f.ir_in    = w_in_hold ? r_hold_buf : io_f.imem_rdata;
    assign io_f.ir_pc    = w_in_hold ? r_hold_pc : r_req_addr;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_read     <= 1'b0;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_hold_buf <= '0;
            r_hold_pc  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state    <= REQ;
                    r_read     <= 1'b1;
                    r_req_addr <= r_pc;
                end
                REQ: begin
                    if (io_f.redirect) begin
                        r_pc <= io_f.redirect_pc;
                        if (io_f.imem_resp) r_req_addr <= io_f.redirect_pc;
                        else r_state <= SQUASH;
                    end else if (io_f.imem_resp) begin
                        r_pc <= w_next_addr;
                        if (!io_f.stall) begin
                            r_req_addr <= w_next_addr;
                        end else begin
                            r_hold_buf <= io_f.imem_rdata;
                            r_hold_pc  <= r_req_addr;
                            r_read     <= 1'b0;
                            r_state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (io_f.redirect) begin
                        r_pc       <= io_f.redirect_pc;
                        r_req_addr <= io_f.redirect_pc;
                        r_read     <= 1'b1;
                        r_state    <= REQ;
                    end else if (!io_f.stall) begin
                        r_req_addr <= r_pc;
                        r_read     <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                SQUASH: begin
                    // The stale read must complete; the newest redirect target wins.
                    if (io_f.redirect) r_pc <= io_f.redirect_pc;
                    if (io_f.imem_resp) begin
                        r_req_addr <= io_f.redirect ? io_f.redirect_pc : r_pc;
                        r_state    <= REQ;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed sequences with literal expectations, then randomized
// traffic checked every cycle against a transaction-level fetch model.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    fetch_ctrl_if bus();
    fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .io_f(bus));
    int checks = 0;
    int errors = 0;
    // Model: an outstanding read (addr, squashed or not), an optional held word, next fetch pc.
    logic        m_on = 1'b0, m_idle = 1'b1, m_rv = 1'b0, m_stale = 1'b0, m_hv = 1'b0;
    logic [31:0] m_raddr = '0, m_hdata = '0, m_hpc = '0, m_pc = 32'h60;
    logic        n_rst = 1'b0, n_resp = 1'b0, n_stall = 1'b0, n_redir = 1'b0, rnd = 1'b0;
    logic [31:0] n_rdata = '0, n_rpc = '0;
    initial begin
        bus.imem_resp = 1'b0;
        bus.imem_rdata = '0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_step();
        if (!rst_n) begin
            m_on = 1'b1; m_idle = 1'b1; m_rv = 1'b0; m_hv = 1'b0; m_stale = 1'b0; m_pc = 32'h60;
        end else if (m_on) begin
            if (m_idle) begin
                m_idle = 1'b0; m_rv = 1'b1; m_raddr = m_pc; m_stale = 1'b0;
            end else if (m_hv) begin
                if (bus.redirect) begin
                    m_hv = 1'b0; m_pc = bus.redirect_pc; m_rv = 1'b1; m_raddr = bus.redirect_pc; m_stale = 1'b0;
                end else if (!bus.stall) begin
                    m_hv = 1'b0; m_rv = 1'b1; m_raddr = m_pc; m_stale = 1'b0;
                end
            end else if (m_rv) begin
                if (bus.redirect) begin
                    m_pc = bus.redirect_pc;
                    if (bus.imem_resp) begin m_raddr = bus.redirect_pc; m_stale = 1'b0; end
                    else m_stale = 1'b1;
                end else if (bus.imem_resp) begin
                    if (m_stale) begin
                        m_stale = 1'b0; m_raddr = m_pc;
                    end else if (!bus.stall) begin
                        m_pc = m_raddr + 32'd4; m_raddr = m_pc;
                    end else begin
                        m_hv = 1'b1; m_hdata = bus.imem_rdata; m_hpc = m_raddr;
                        m_pc = m_raddr + 32'd4; m_rv = 1'b0;
                    end
                end
            end
        end
    endtask
    always @(negedge clk) begin
        if (m_on) begin
            logic e_read, e_flush, e_load;
            e_read  = !m_idle && m_rv;
            e_flush = !m_idle && bus.redirect;
            e_load  = !m_idle && !bus.redirect && !bus.stall &&
                      (m_hv || (m_rv && !m_stale && bus.imem_resp));
            check("imem_read", {31'd0, bus.imem_read}, {31'd0, e_read});
            check("ir_flush", {31'd0, bus.ir_flush}, {31'd0, e_flush});
            check("ir_load", {31'd0, bus.ir_load}, {31'd0, e_load});
            if (e_read) check("imem_address", bus.imem_address, m_raddr);
            if (e_load) begin
                check("ir_in", bus.ir_in, m_hv ? m_hdata : bus.imem_rdata);
                check("ir_pc", bus.ir_pc, m_hv ? m_hpc : m_raddr);
            end
        end
    end
    // One cycle: model consumes this edge, new inputs are applied, return at negedge.
    task automatic go();
        @(posedge clk);
        model_step();
        #1;
        if (rnd) begin
            n_rst   = $urandom_range(0, 149) != 0;
            n_resp  = bus.imem_read && ($urandom_range(0, 2) == 0);
            n_rdata = $urandom;
            n_stall = $urandom_range(0, 2) == 0;
            n_redir = $urandom_range(0, 7) == 0;
            n_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom;
        end
        rst_n = n_rst;
        bus.imem_resp = n_resp;
        bus.imem_rdata = n_rdata;
        bus.stall = n_stall;
        bus.redirect = n_redir;
        bus.redirect_pc = n_rpc;
        @(negedge clk);
    endtask
    task automatic lit(input string name, input logic rd, input logic ld, input logic fl);
        check({name, ".read"}, {31'd0, bus.imem_read}, {31'd0, rd});
        check({name, ".load"}, {31'd0, bus.ir_load}, {31'd0, ld});
        check({name, ".flush"}, {31'd0, bus.ir_flush}, {31'd0, fl});
    endtask
    initial begin
        // reset held, then one IDLE cycle, then fetch at 0x60
        go(); go();
        lit("t1_reset", 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        go();
        lit("t1_idle", 1'b0, 1'b0, 1'b0);
        go();
        lit("t1_req", 1'b1, 1'b0, 1'b0);
        check("t1_addr", bus.imem_address, 32'h60);
        // streaming
        n_resp = 1'b1; n_rdata = 32'h13;
        go();
        lit("t2_a", 1'b1, 1'b1, 1'b0);
        check("t2_pc0", bus.ir_pc, 32'h60);
        check("t2_in0", bus.ir_in, 32'h13);
        go();
        check("t2_addr1", bus.imem_address, 32'h64);
        check("t2_pc1", bus.ir_pc, 32'h64);
        go();
        check("t2_pc2", bus.ir_pc, 32'h68);
        n_resp = 1'b0;
        go();
        check("t2_addr3", bus.imem_address, 32'h6C);
        // stall into hold buffer
        n_resp = 1'b1; n_stall = 1'b1; n_rdata = 32'hAAAA_5555;
        go();
        lit("t3_resp", 1'b1, 1'b0, 1'b0);
        n_resp = 1'b0;
        go(); go();
        lit("t3_hold", 1'b0, 1'b0, 1'b0);
        n_stall = 1'b0;
        go();
        lit("t3_rel", 1'b0, 1'b1, 1'b0);
        check("t3_in", bus.ir_in, 32'hAAAA_5555);
        check("t3_pc", bus.ir_pc, 32'h6C);
        go();
        check("t3_next", bus.imem_address, 32'h70);
        // redirect with read in flight
        n_redir = 1'b1; n_rpc = 32'h200;
        go();
        lit("t4_redir", 1'b1, 1'b0, 1'b1);
        n_redir = 1'b0;
        go();
        lit("t4_sq", 1'b1, 1'b0, 1'b0);
        check("t4_stale", bus.imem_address, 32'h70);
        n_resp = 1'b1; n_rdata = 32'hDEAD_BEEF;
        go();
        lit("t4_drop", 1'b1, 1'b0, 1'b0);
        n_resp = 1'b0;
        go();
        check("t4_next", bus.imem_address, 32'h200);
        // resp+redirect collision, then redirect while holding
        n_resp = 1'b1; n_redir = 1'b1; n_rpc = 32'h300; n_rdata = 32'h1111;
        go();
        lit("t5_coll", 1'b1, 1'b0, 1'b1);
        n_resp = 1'b0; n_redir = 1'b0;
        go();
        check("t5_next", bus.imem_address, 32'h300);
        n_resp = 1'b1; n_stall = 1'b1; n_rdata = 32'h2222;
        go();
        n_resp = 1'b0;
        go();
        n_redir = 1'b1; n_rpc = 32'h400; n_stall = 1'b0;
        go();
        lit("t5_hold_redir", 1'b0, 1'b0, 1'b1);
        n_redir = 1'b0;
        go();
        lit("t5_after", 1'b1, 1'b0, 1'b0);
        check("t5_addr", bus.imem_address, 32'h400);
        // wrap, then reset during SQUASH
        n_resp = 1'b1; n_redir = 1'b1; n_rpc = 32'hFFFF_FFFC;
        go();
        n_redir = 1'b0; n_rdata = 32'h3333;
        go();
        check("t6_wrap_pc", bus.ir_pc, 32'hFFFF_FFFC);
        n_resp = 1'b0;
        go();
        check("t6_wrap_addr", bus.imem_address, 32'h0);
        n_redir = 1'b1; n_rpc = 32'h500;
        go();
        n_redir = 1'b0; n_rst = 1'b0;
        go();
        n_rst = 1'b1;
        go();
        lit("t6_rst_idle", 1'b0, 1'b0, 1'b0);
        go();
        check("t6_rst_addr", bus.imem_address, 32'h60);
        n_resp = 1'b1; n_rdata = 32'h77;
        go();
        check("t6_fresh_in", bus.ir_in, 32'h77);
        check("t6_fresh_pc", bus.ir_pc, 32'h60);
        // randomized traffic against the model
        rnd = 1'b1;
        for (int i = 0; i < 4000; i++) go();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
